// File: rtl/mem_stage_ctrl.sv
// Memory-stage access controller for a pipelined core.
// It accepts a load or store from the execute stage and issues it to the backing
// memory as a single-cycle strobe. It then waits, with a timeout, for dm_done and
// returns a one-cycle response carrying the data, hit and error flags.
// Optional feature: define MEM_STAGE_ALIGN_CHECK_EN to reject misaligned accesses.
module mem_stage_ctrl #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_rd,
  input  logic              ex_wr,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              ex_dump,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_valid,
  output logic              stall,
  output logic              err,
  output logic              hit,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  output logic              dm_rd,
  output logic              dm_wr,
  output logic              dm_dump,
  input  logic [DATA_W-1:0] dm_rdata,
  input  logic              dm_done,
  input  logic              dm_hit,
  input  logic              dm_err
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;      // registered op: 1 = store, 0 = load
  logic [7:0]        cnt_q, cnt_d;
  logic [8:0]        cnt_inc;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              hit_q, hit_d;

  logic              accept;
  logic              misaligned;
  logic              bad_req;

  // rst_n gates acceptance so stall stays low while reset is held.
  assign accept = rst_n & ex_valid & (ex_rd | ex_wr) &
                  ((state_q == StIdle) | (state_q == StResp));

`ifdef MEM_STAGE_ALIGN_CHECK_EN
  localparam int unsigned AlignBits = $clog2(DATA_W / 8);
  assign misaligned = |ex_addr[AlignBits-1:0];
`else
  assign misaligned = 1'b0;
`endif

  assign bad_req = (ex_rd & ex_wr) | misaligned;
  assign cnt_inc = {1'b0, cnt_q} + 9'd1;

  // Next-state logic: acceptance, issue/wait sequencing, response capture.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    hit_d   = hit_q;
    unique case (state_q)
      StIssue, StWait: begin
        if (dm_done) begin
          state_d = StResp;
          rdata_d = wr_q ? '0 : dm_rdata;
          err_d   = dm_err;
          hit_d   = dm_hit;
        end else if (state_q == StIssue) begin
          state_d = StWait;
        end else if (cnt_inc >= 9'(MAX_WAIT)) begin
          // Timeout: counter has reached MAX_WAIT with no completion.
          state_d = StResp;
          cnt_d   = cnt_inc[7:0];
          rdata_d = '0;
          err_d   = 1'b1;
          hit_d   = 1'b0;
        end else begin
          cnt_d = cnt_inc[7:0];
        end
      end
      default: begin
        // StIdle and StResp both accept; dm_done is ignored here.
        if (accept) begin
          addr_d  = ex_addr;
          wdata_d = ex_wdata;
          wr_d    = ex_wr;
          if (bad_req) begin
            state_d = StResp;
            rdata_d = '0;
            err_d   = 1'b1;
            hit_d   = 1'b0;
          end else begin
            state_d = StIssue;
            cnt_d   = '0;
          end
        end else begin
          state_d = StIdle;
        end
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      hit_q   <= hit_d;
    end
  end

  // Output decode from the current state and the captured response.
  always_comb begin
    mem_valid = (state_q == StResp);
    err       = mem_valid & err_q;
    hit       = mem_valid & hit_q;
    mem_rdata = rdata_q;
    stall     = (state_q == StIssue) | (state_q == StWait) | accept;
    dm_rd     = (state_q == StIssue) & ~wr_q;
    dm_wr     = (state_q == StIssue) & wr_q;
    dm_addr   = addr_q;
    dm_wdata  = wdata_q;
    dm_dump   = ex_dump;
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl with a transaction-level reference model.
module tb_mem_stage_ctrl;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int MW = 8;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
  localparam bit AlignEn = 1'b1;
`else
  localparam bit AlignEn = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic ex_valid, ex_rd, ex_wr, ex_dump;
  logic [AW-1:0] ex_addr;
  logic [DW-1:0] ex_wdata;
  logic [DW-1:0] mem_rdata;
  logic mem_valid, stall, err, hit;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic dm_rd, dm_wr, dm_dump;
  logic [DW-1:0] dm_rdata;
  logic dm_done, dm_hit, dm_err;

  int total = 0;
  int bad = 0;

  mem_stage_ctrl #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_wr(ex_wr),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_dump(ex_dump), .mem_rdata(mem_rdata),
    .mem_valid(mem_valid), .stall(stall), .err(err), .hit(hit), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_dump(dm_dump),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_hit(dm_hit), .dm_err(dm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One access: request at cycle 0, dm_done 'dly' cycles after the issue cycle.
  task automatic run_txn(input string nm, input logic rd, input logic wr,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input int dly, input logic [DW-1:0] rdat,
                         input logic dhit, input logic derr);
    bit illegal, timeout, success, seq_bad;
    int exp_lat, got_lat, n_rd, n_wr, exp_nrd, exp_nwr;
    logic [DW-1:0] exp_rdata, got_rdata, s_wdata;
    logic [AW-1:0] s_addr;
    logic exp_err, exp_hit, got_err, got_hit;
    illegal   = (rd && wr) || (AlignEn && addr[0]);
    timeout   = !illegal && (dly > MW);
    success   = !illegal && !timeout;
    exp_lat   = illegal ? 1 : (success ? 2 + dly : 2 + MW);
    exp_err   = !success || derr;
    exp_hit   = success && dhit;
    exp_rdata = (success && rd) ? rdat : '0;
    exp_nrd   = (!illegal && rd) ? 1 : 0;
    exp_nwr   = (!illegal && wr) ? 1 : 0;
    got_lat = -1; n_rd = 0; n_wr = 0; seq_bad = 0;
    got_rdata = '0; got_err = 0; got_hit = 0; s_addr = '0; s_wdata = '0;

    @(negedge clk);
    ex_valid = 1; ex_rd = rd; ex_wr = wr; ex_addr = addr; ex_wdata = wdata;
    ex_dump = 1'($urandom); dm_done = 0; dm_rdata = DW'($urandom);
    #1;
    total++;
    if (stall !== 1'b1) begin bad++; $display("FAIL %s accept_stall got=%b exp=1", nm, stall); end
    total++;
    if (dm_dump !== ex_dump)
      begin bad++; $display("FAIL %s dm_dump got=%b exp=%b", nm, dm_dump, ex_dump); end

    for (int c = 1; c <= 40 && got_lat < 0; c++) begin
      @(negedge clk);
      ex_valid = 0; ex_rd = 0; ex_wr = 0; ex_addr = AW'($urandom); ex_wdata = DW'($urandom);
      dm_done  = (c == dly + 1);
      dm_rdata = dm_done ? rdat : DW'($urandom);
      dm_hit   = dm_done ? dhit : 1'($urandom);
      dm_err   = dm_done ? derr : 1'($urandom);
      #1;
      if (dm_rd === 1'b1) begin n_rd++; s_addr = dm_addr; end
      if (dm_wr === 1'b1) begin n_wr++; s_addr = dm_addr; s_wdata = dm_wdata; end
      if (mem_valid === 1'b1) begin
        got_lat = c; got_rdata = mem_rdata; got_err = err; got_hit = hit;
        if (stall !== 1'b0) seq_bad = 1;
      end else if (stall !== 1'b1 || err !== 1'b0 || hit !== 1'b0) begin
        seq_bad = 1;
      end
    end

    total++;
    if (got_lat != exp_lat)
      begin bad++; $display("FAIL %s latency got=%0d exp=%0d", nm, got_lat, exp_lat); end
    total++;
    if (got_err !== exp_err)
      begin bad++; $display("FAIL %s err got=%b exp=%b", nm, got_err, exp_err); end
    total++;
    if (got_hit !== exp_hit)
      begin bad++; $display("FAIL %s hit got=%b exp=%b", nm, got_hit, exp_hit); end
    if (!illegal) begin
      total++;
      if (got_rdata !== exp_rdata)
        begin bad++; $display("FAIL %s rdata got=%h exp=%h", nm, got_rdata, exp_rdata); end
    end
    total++;
    if (n_rd != exp_nrd || n_wr != exp_nwr)
      begin bad++; $display("FAIL %s strobes got=%0d/%0d exp=%0d/%0d", nm, n_rd, n_wr,
                            exp_nrd, exp_nwr); end
    if (!illegal) begin
      total++;
      if (s_addr !== addr)
        begin bad++; $display("FAIL %s dm_addr got=%h exp=%h", nm, s_addr, addr); end
    end
    if (exp_nwr == 1) begin
      total++;
      if (s_wdata !== wdata)
        begin bad++; $display("FAIL %s dm_wdata got=%h exp=%h", nm, s_wdata, wdata); end
    end
    total++;
    if (seq_bad) begin bad++; $display("FAIL %s stall_flags got=bad exp=clean", nm); end

    @(negedge clk);
    dm_done = 0;
    #1;
    total++;
    if (mem_valid !== 1'b0 || err !== 1'b0 || hit !== 1'b0)
      begin bad++; $display("FAIL %s post_idle got=%b%b%b exp=000", nm, mem_valid, err, hit); end
    if (!illegal) begin
      total++;
      if (mem_rdata !== exp_rdata)
        begin bad++; $display("FAIL %s rdata_hold got=%h exp=%h", nm, mem_rdata, exp_rdata); end
    end
  endtask

  task automatic test_reset();
    rst_n = 0; ex_valid = 1; ex_rd = 1; ex_wr = 0; ex_addr = 16'h1234; ex_wdata = 16'h5678;
    ex_dump = 1; dm_rdata = 16'hFFFF; dm_done = 1; dm_hit = 1; dm_err = 1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({mem_valid, stall, err, hit, dm_rd, dm_wr, mem_rdata, dm_addr, dm_wdata} !== '0)
      begin bad++; $display("FAIL reset outputs got=%b%b%b%b%b%b %h %h %h exp=all0", mem_valid,
                            stall, err, hit, dm_rd, dm_wr, mem_rdata, dm_addr, dm_wdata); end
    total++;
    if (dm_dump !== 1'b1) begin bad++; $display("FAIL reset dm_dump got=%b exp=1", dm_dump); end
    @(negedge clk);
    ex_valid = 0; ex_rd = 0; dm_done = 0; ex_dump = 0;
    rst_n = 1;
  endtask

  task automatic test_directed();
    run_txn("load_hit", 1, 0, 16'h0010, 16'h0000, 0, 16'hBEEF, 1, 0);
    run_txn("store_wait3", 0, 1, 16'h0020, 16'h1234, 3, 16'hDEAD, 0, 0);
    run_txn("load_timeout", 1, 0, 16'h0030, 16'h0000, 100, 16'hCAFE, 1, 0);
    run_txn("rd_and_wr", 1, 1, 16'h0040, 16'h9999, 0, 16'h7777, 1, 0);
    run_txn("load_0011", 1, 0, 16'h0011, 16'h0000, 0, 16'h4321, 0, 0);
    run_txn("done_last_wait", 1, 0, 16'h0050, 16'h0000, MW, 16'h1111, 1, 1);
    run_txn("done_in_resp", 0, 1, 16'h0060, 16'hABCD, MW + 1, 16'h2222, 1, 0);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    ex_valid = 1; ex_rd = 1; ex_wr = 0; ex_addr = 16'h0040; dm_done = 0;
    @(negedge clk);
    ex_valid = 0; ex_rd = 0; dm_done = 1; dm_rdata = 16'hA5A5; dm_hit = 0; dm_err = 0;
    #1;
    total++;
    if (dm_rd !== 1'b1) begin bad++; $display("FAIL b2b first_rd got=%b exp=1", dm_rd); end
    @(negedge clk);
    dm_done = 0; ex_valid = 1; ex_wr = 1; ex_addr = 16'h0042; ex_wdata = 16'h5A5A;
    #1;
    total++;
    if ({mem_valid, stall, mem_rdata} !== {1'b1, 1'b1, 16'hA5A5})
      begin bad++; $display("FAIL b2b resp1 got=%b%b %h exp=11 a5a5", mem_valid, stall,
                            mem_rdata); end
    @(negedge clk);
    ex_valid = 0; ex_wr = 0; dm_done = 1; dm_hit = 1; dm_rdata = 16'h3333;
    #1;
    total++;
    if ({dm_wr, dm_rd, mem_valid, dm_addr, dm_wdata} !== {3'b100, 16'h0042, 16'h5A5A})
      begin bad++; $display("FAIL b2b issue2 got=%b%b%b %h %h exp=100 0042 5a5a", dm_wr, dm_rd,
                            mem_valid, dm_addr, dm_wdata); end
    @(negedge clk);
    dm_done = 0;
    #1;
    total++;
    if ({mem_valid, hit, err, mem_rdata} !== {3'b110, 16'h0000})
      begin bad++; $display("FAIL b2b resp2 got=%b%b%b %h exp=110 0000", mem_valid, hit, err,
                            mem_rdata); end
    @(negedge clk);
    #1;
    total++;
    if (mem_valid !== 1'b0) begin bad++; $display("FAIL b2b idle got=%b exp=0", mem_valid); end
  endtask

  task automatic test_reset_mid();
    bit spurious;
    spurious = 0;
    @(negedge clk);
    ex_valid = 1; ex_rd = 1; ex_wr = 0; ex_addr = 16'h0070; dm_done = 0;
    @(negedge clk);
    ex_valid = 0; ex_rd = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    total++;
    if ({mem_valid, stall, err, hit, dm_rd, dm_wr, mem_rdata, dm_addr, dm_wdata} !== '0)
      begin bad++; $display("FAIL rst_mid outputs got=%b%b %h %h exp=all0", mem_valid, stall,
                            mem_rdata, dm_addr); end
    @(negedge clk);
    rst_n = 1; dm_done = 1; dm_rdata = 16'hFACE; dm_hit = 1;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (mem_valid !== 1'b0 || stall !== 1'b0) spurious = 1;
      @(negedge clk);
      dm_done = 0;
    end
    total++;
    if (spurious) begin bad++; $display("FAIL rst_mid late_done got=valid exp=none"); end
    run_txn("after_reset", 1, 0, 16'h0080, 16'h0000, 2, 16'h600D, 1, 0);
  endtask

  task automatic test_random();
    int op;
    logic rd, wr;
    for (int i = 0; i < 30; i++) begin
      op = $urandom_range(0, 9);
      rd = (op == 0) || (op < 5);
      wr = (op == 0) || (op >= 5);
      run_txn("random", rd, wr, AW'($urandom), DW'($urandom), $urandom_range(0, MW + 2),
              DW'($urandom), 1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL provide parameter DATA_W, default 16, meaning data path width in bits; legal values are multiples of 8, minimum 16.
REQ-002 SHALL provide parameter ADDR_W, default 16, meaning byte address width.
REQ-003 SHALL provide parameter MAX_WAIT, default 8, meaning the number of WAIT cycles before timeout; legal range is 1..255.
REQ-004 Ports (name, direction, width, meaning):
- clk  in  1  sole clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  pipeline presents an access this cycle.
- ex_rd  in  1  load request.
- ex_wr  in  1  store request.
- ex_addr  in  ADDR_W  byte address.
- ex_wdata  in  DATA_W  store data.
- ex_dump  in  1  memory dump request.
- mem_rdata  out  DATA_W  load result.
- mem_valid  out  1  response pulse; one cycle per accepted access.
- stall  out  1  pipeline hold.
- err  out  1  error flag; qualified by mem_valid.
- hit  out  1  cache hit flag; qualified by mem_valid.
- dm_addr  out  ADDR_W  backing-memory address.
- dm_wdata  out  DATA_W  backing-memory store data.
- dm_rd  out  1  backing-memory read strobe.
- dm_wr  out  1  backing-memory write strobe.
- dm_dump  out  1  equals ex_dump (combinational).
- dm_rdata  in  DATA_W  backing-memory read data.
- dm_done  in  1  access complete.
- dm_hit  in  1  cache hit.
- dm_err  in  1  backing-memory error.

Function
REQ-005 SHALL implement states IDLE, ISSUE, WAIT and RESP.
REQ-006 SHALL accept a request in IDLE or RESP when ex_valid & (ex_rd | ex_wr).
- On acceptance: register addr, wdata and op; move to ISSUE.
REQ-007 A request with ex_rd & ex_wr both high SHALL be illegal: no issue, go to RESP with err=1.
REQ-008 SHALL drive dm_rd/dm_wr (per the registered op) high for exactly the ISSUE cycle, with dm_addr/dm_wdata from the registers.
REQ-009 ISSUE SHALL go to RESP if dm_done is high, otherwise to WAIT.
REQ-010 WAIT SHALL keep dm_rd/dm_wr low, increment a wait counter, and go to RESP on dm_done.
REQ-011 WAIT SHALL time out when the counter reaches MAX_WAIT without dm_done: go to RESP with err=1, hit=0, mem_rdata=0.
REQ-012 On dm_done, SHALL capture dm_hit and dm_err; for loads SHALL also capture dm_rdata, for stores mem_rdata=0.
REQ-013 RESP SHALL last one cycle with mem_valid=1, err and hit as captured; it then goes to IDLE, or to ISSUE if a new request is accepted.
REQ-014 stall SHALL be 1 in ISSUE and WAIT, and in IDLE/RESP in the acceptance cycle; it is 0 otherwise.
- Minimum latency: accept cycle 0, ISSUE cycle 1, mem_valid cycle 2.
REQ-015 mem_valid, err and hit SHALL be 0 outside RESP; mem_rdata SHALL hold its last value outside RESP.
REQ-016 dm_done in IDLE or RESP SHALL be ignored.
REQ-017 The wait counter SHALL clear on entry to ISSUE and never wrap.

Reset
REQ-018 rst_n low SHALL asynchronously force IDLE, clear all registers, and drive all outputs to 0 except dm_dump.
REQ-019 Reset during ISSUE/WAIT SHALL abandon the access with no mem_valid; a late dm_done is ignored per REQ-016.

Configuration
REQ-020 Macro MEM_STAGE_ALIGN_CHECK_EN defined: any accepted request whose low log2(DATA_W/8) address bits are nonzero SHALL skip ISSUE, assert no strobe, and go to RESP with err=1.
REQ-021 Macro undefined: SHALL perform no alignment check and pass addresses unchanged.

Verification
REQ-022 Load 0x0010 with dm_done in ISSUE, dm_rdata=0xBEEF, dm_hit=1 -> mem_valid cycle 2, mem_rdata=0xBEEF, hit=1, err=0, stall high for cycles 0-1.
REQ-023 Store 0x0020 with data 0x1234, dm_done 3 cycles after ISSUE -> dm_wr for one cycle, dm_wdata=0x1234, mem_valid at cycle 5, mem_rdata=0, hit=0.
REQ-024 Load with dm_done never asserted, MAX_WAIT=8 -> err=1, mem_rdata=0, mem_valid 10 cycles after acceptance.
REQ-025 ex_rd=ex_wr=1 -> no dm strobes, err=1 with mem_valid at cycle 1.
REQ-026 With MEM_STAGE_ALIGN_CHECK_EN: load 0x0011 -> err=1, no dm_rd. Without the macro: dm_rd is issued to 0x0011.
REQ-027 rst_n pulsed low during WAIT, then dm_done arrives -> all outputs 0, no mem_valid; the next load completes normally.
